pc_unit: RTL

Parametrised program-counter unit for the processor fetch stage. It holds the current PC and selects the next PC from several sources: sequential, branch, absolute jump, call/return via a small return-address stack (RAS), and exception vector. It supports fetch stalls. The PC output drives instruction-memory address generation; control inputs come from the decode/control unit.

---
 rtl/pc_unit_if.sv | 31 +++
 rtl/pc_unit.sv | 129 ++++++++++++
 2 files changed

// File: rtl/pc_unit_if.sv
// Fetch-stage control and status bundle for pc_unit.
// The control side (master) drives redirects; the PC unit (slave) returns PC and RAS status.
interface pc_unit_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OFF_W = 16
);
  logic             stall;
  logic             exception;
  logic             branch_taken;
  logic [OFF_W-1:0] branch_offset;
  logic             jump;
  logic [WIDTH-1:0] jump_target;
  logic             call;
  logic             ret;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus4;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_overflow;
  logic             ras_underflow;

  modport master (
    output stall, exception, branch_taken, branch_offset, jump, jump_target, call, ret,
    input  pc, pc_plus4, ras_empty, ras_full, ras_overflow, ras_underflow
  );

  modport slave (
    input  stall, exception, branch_taken, branch_offset, jump, jump_target, call, ret,
    output pc, pc_plus4, ras_empty, ras_full, ras_overflow, ras_underflow
  );
endinterface

// File: rtl/pc_unit.sv
// Program-counter unit: next-PC selection (sequential, branch, jump, call/return, exception)
// with a circular return-address stack and registered overflow/underflow pulses.
module pc_unit #(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = 32'h8000_0180,
  parameter int unsigned      STEP         = 4,
  parameter int unsigned      OFF_W        = 16,
  parameter int unsigned      RAS_DEPTH    = 4
) (
  input  logic    clock,
  input  logic    reset,
  pc_unit_if.slave bus
);

  localparam int unsigned PtrW = $clog2(RAS_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(RAS_DEPTH);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] off_ext;
  logic [WIDTH-1:0] br_target;
  logic [WIDTH-1:0] jmp_target;
  logic [PtrW-1:0]  top_q, top_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_we;
  logic [PtrW-1:0]  ras_widx;
  logic [WIDTH-1:0] ras_wdata;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];

  assign pc_plus4   = pc_q + WIDTH'(STEP);
  assign off_ext    = WIDTH'($signed(bus.branch_offset));
  assign br_target  = pc_plus4 + (off_ext << 2);
  assign jmp_target = {bus.jump_target[WIDTH-1:2], 2'b00};
  assign ras_empty  = (cnt_q == '0);
  assign ras_full   = (cnt_q == CntMax);

  always_comb begin
    pc_d      = pc_q;
    top_d     = top_q;
    cnt_d     = cnt_q;
    ovf_d     = 1'b0;
    unf_d     = 1'b0;
    ras_we    = 1'b0;
    ras_widx  = top_q;
    ras_wdata = pc_plus4;

    if (bus.exception) begin
      pc_d  = EXC_VECTOR;
      cnt_d = '0;
    end else if (bus.stall) begin
      // Hold everything; pulses simply fall back to zero.
    end else if (bus.ret && bus.call) begin
      ras_we = 1'b1;
      if (ras_empty) begin
        unf_d    = 1'b1;
        pc_d     = pc_plus4;
        top_d    = top_q + PtrW'(1);
        ras_widx = top_q + PtrW'(1);
        cnt_d    = CntW'(1);
      end else begin
        // Pop then push lands in the same slot, so pointer and count stay put.
        pc_d = ras_q[top_q];
      end
    end else if (bus.ret) begin
      if (ras_empty) begin
        unf_d = 1'b1;
        pc_d  = pc_plus4;
      end else begin
        pc_d  = ras_q[top_q];
        top_d = top_q - PtrW'(1);
        cnt_d = cnt_q - CntW'(1);
      end
    end else if (bus.call) begin
      pc_d     = jmp_target;
      ras_we   = 1'b1;
      top_d    = top_q + PtrW'(1);
      ras_widx = top_q + PtrW'(1);
      // On a full stack the pointer advance overwrites the oldest entry.
      if (ras_full) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end else if (bus.jump) begin
      pc_d = jmp_target;
    end else if (bus.branch_taken) begin
      pc_d = br_target;
    end else begin
      pc_d = pc_plus4;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q  <= RESET_VECTOR;
      top_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      top_q <= top_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Entry contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clock) begin
    if (ras_we) begin
      ras_q[ras_widx] <= ras_wdata;
    end
  end

  assign bus.pc            = pc_q;
  assign bus.pc_plus4      = pc_plus4;
  assign bus.ras_empty     = ras_empty;
  assign bus.ras_full      = ras_full;
  assign bus.ras_overflow  = ovf_q;
  assign bus.ras_underflow = unf_q;

endmodule
